program_counter_unit: RTL

- Generates the 10-bit instruction address that drives input A of the CPU address multiplexer.
- Holds the program counter register and a small hardware return-address stack.
- Applies sequential increment, unconditional jump, conditional branch, call/return, stall and halt.
- Output is registered; the address multiplexer consumes pc_address directly, with no extra pipeline stage.

---
 rtl/program_counter_unit.sv | 85 ++++++++
 1 files changed

// File: rtl/program_counter_unit.sv
// rtl/program_counter_unit.sv - program counter with hardware return-address stack
module program_counter_unit #(
    parameter int                    ADDR_WIDTH   = 10,
    parameter int                    STACK_DEPTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          halt,
    input  logic                          stall,
    input  logic                          jump_enable,
    input  logic                          branch_enable,
    input  logic                          branch_condition,
    input  logic                          call_enable,
    input  logic                          return_enable,
    input  logic [ADDR_WIDTH-1:0]         jump_address,
    output logic [ADDR_WIDTH-1:0]         pc_address,
    output logic                          halted,
    output logic [$clog2(STACK_DEPTH):0]  stack_count,
    output logic                          stack_overflow,
    output logic                          stack_underflow
);
    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [PTR_W-1:0]      push_ptr;
    logic [PTR_W-1:0]      top_ptr;
    logic                  active;
    logic                  stack_full;
    logic                  stack_empty;
    logic                  do_push;
    logic                  take_jump;

    assign pc_inc      = pc_address + ADDR_WIDTH'(1);
    assign active      = !halted && !halt && !stall;
    assign stack_full  = (stack_count == CNT_W'(STACK_DEPTH));
    assign stack_empty = (stack_count == '0);
    assign do_push     = active && !return_enable && call_enable && !stack_full;
    assign take_jump   = jump_enable || (branch_enable && branch_condition);

    // Low pointer bits minus one wrap to DEPTH-1 when full, giving the top entry.
    assign push_ptr = stack_count[PTR_W-1:0];
    assign top_ptr  = push_ptr - PTR_W'(1);

    always_ff @(posedge clock) begin
        if (do_push) begin
            stack_mem[push_ptr] <= pc_inc;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_address      <= RESET_VECTOR;
            halted          <= 1'b0;
            stack_count     <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else if (halted || halt) begin
            halted <= 1'b1;
        end else if (!stall) begin
            if (return_enable) begin
                if (stack_empty) begin
                    stack_underflow <= 1'b1;
                    pc_address      <= pc_inc;
                end else begin
                    pc_address  <= stack_mem[top_ptr];
                    stack_count <= stack_count - CNT_W'(1);
                end
            end else if (call_enable) begin
                pc_address <= jump_address;
                if (stack_full) begin
                    stack_overflow <= 1'b1;
                end else begin
                    stack_count <= stack_count + CNT_W'(1);
                end
            end else if (take_jump) begin
                pc_address <= jump_address;
            end else begin
                pc_address <= pc_inc;
            end
        end
    end
endmodule
